// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned NWB       = 2;

  // Writeback port indices; the LSU port carries the younger result.
  typedef enum int unsigned {
    WB_ALU = 0,
    WB_LSU = 1
  } wb_port_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bus of the register file: read ports, two writeback ports, issue and flush.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic                busy_any;

  modport master (
    output rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd, flush,
    input  rs_data, rs_busy, busy_any
  );

  modport slave (
    input  rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd, flush,
    output rs_data, rs_busy, busy_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: flush clears all, issue sets, writeback clears, issue beats writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [$clog2(NREGS)-1:0] wa0,
  input  logic                     we1,
  input  logic [$clog2(NREGS)-1:0] wa1,
  input  logic                     iss_valid,
  input  logic [$clog2(NREGS)-1:0] iss_rd,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy,
  output logic                     busy_any
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (iss_valid && (iss_rd == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_nxt[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_any <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_any <= |busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and RAW scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NWB-1:0]  wb_we;
  logic [AW-1:0]   wb_wa [NWB];
  logic [XLEN-1:0] wb_wd [NWB];
  logic [XLEN-1:0] mem   [NREGS];
  logic [NREGS-1:0] busy;

  assign wb_we[WB_ALU] = bus.we0;
  assign wb_wa[WB_ALU] = bus.wa0;
  assign wb_wd[WB_ALU] = bus.wd0;
  assign wb_we[WB_LSU] = bus.we1;
  assign wb_wa[WB_LSU] = bus.wa1;
  assign wb_wd[WB_LSU] = bus.wd1;

  // Ports written in index order so the LSU port lands last and wins a shared address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_we[p] && !((ZERO_REG != 0) && (wb_wa[p] == AW'(REG_ZERO)))) begin
          mem[wb_wa[p]] <= wb_wd[p];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .we0       (wb_we[WB_ALU]),
    .wa0       (wb_wa[WB_ALU]),
    .we1       (wb_we[WB_LSU]),
    .wa1       (wb_wa[WB_LSU]),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .busy      (busy),
    .busy_any  (bus.busy_any)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            is_zero;
    logic            hit_alu;
    logic            hit_lsu;
    logic [XLEN-1:0] rd_data;

    assign addr    = bus.rs_addr[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == AW'(REG_ZERO));
    assign hit_alu = wb_we[WB_ALU] && (wb_wa[WB_ALU] == addr);
    assign hit_lsu = wb_we[WB_LSU] && (wb_wa[WB_LSU] == addr);

    // Younger LSU result bypasses ahead of the ALU result, both ahead of the array.
    assign rd_data = is_zero ? '0 :
                     hit_lsu ? wb_wd[WB_LSU] :
                     hit_alu ? wb_wd[WB_ALU] : mem[addr];

    assign bus.rs_data[k*XLEN +: XLEN] = rd_data;
    assign bus.rs_busy[k] = busy[addr] && !hit_alu && !hit_lsu && !is_zero;
  end

endmodule
